// File: rtl/onenet_link_pkg.sv
// Shared types and helpers for the single-bit link arbiter.
package onenet_link_pkg;

  typedef enum logic [1:0] {
    LINK_IDLE   = 2'd0,
    LINK_SETTLE = 2'd1,
    LINK_SAMPLE = 2'd2
  } link_state_e;

  // Index width that never collapses to zero bits.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onenet_link_arbiter_if.sv
// Requester/link bundle shared by the arbiter (slave) and its environment (master).
interface onenet_link_arbiter_if
  import onenet_link_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = id_width(NUM_REQ)
);

  // Handshake: req is a level sampled only while the arbiter is idle; the
  // winner's req_bit is captured at that decision, gnt is one-hot for the
  // whole transaction, and rsp_valid pulses once with rsp_bit/rsp_id, which
  // then hold until the next pulse. There is no back-pressure on responses.
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_bit;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;
  logic               link_drive;
  logic               link_observe;
  logic               rsp_valid;
  logic               rsp_bit;
  logic [IDW-1:0]     rsp_id;

  modport slave (
    input  req, req_bit, link_observe,
    output gnt, busy, link_drive, rsp_valid, rsp_bit, rsp_id
  );

  modport master (
    output req, req_bit, link_observe,
    input  gnt, busy, link_drive, rsp_valid, rsp_bit, rsp_id
  );

endinterface

// File: rtl/onenet_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping.
module onenet_rr_pick
  import onenet_link_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic               valid_o,
  output logic [IDW-1:0]     idx_o
);

  logic [2*NUM_REQ-1:0] dbl;

  // Lower copy is masked below the pointer; the upper copy supplies the wrap.
  always_comb begin
    dbl     = {req_i, req_i};
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i < int'(ptr_i)) dbl[i] = 1'b0;
    end
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (dbl[i]) begin
        valid_o = 1'b1;
        idx_o   = (i >= NUM_REQ) ? IDW'(i - NUM_REQ) : IDW'(i);
      end
    end
  end

endmodule

// File: rtl/onenet_link_arbiter.sv
// Round-robin sequencer for a shared single-bit drive/observe link:
// grant, drive, settle, sample once, return the sampled bit to the owner.
module onenet_link_arbiter
  import onenet_link_pkg::*;
#(
  parameter int   NUM_REQ       = 4,
  parameter int   SETTLE_CYCLES = 2,
  parameter logic IDLE_VALUE    = 1'b0,
  parameter int   IDW           = id_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  onenet_link_arbiter_if.slave  bus,
  output link_state_e           dbg_state_o,
  output logic [IDW-1:0]        dbg_ptr_o
);

  localparam int CNTW = id_width(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("onenet_link_arbiter: SETTLE_CYCLES must be >= 1");
  end
  if (NUM_REQ < 1) begin : g_bad_num
    $error("onenet_link_arbiter: NUM_REQ must be >= 1");
  end

  link_state_e        state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               drive_q, drive_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_bit_q, rsp_bit_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;

  logic               pick_valid;
  logic [IDW-1:0]     pick_idx;

  onenet_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LINK_IDLE;
      cnt_q       <= '0;
      gnt_q       <= '0;
      drive_q     <= IDLE_VALUE;
      owner_q     <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      drive_q     <= drive_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bit_q   <= rsp_bit_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    drive_d     = drive_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    rsp_bit_d   = rsp_bit_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      LINK_IDLE: begin
        if (pick_valid) begin
          state_d = LINK_SETTLE;
          cnt_d   = CNTW'(SETTLE_CYCLES - 1);
          gnt_d   = NUM_REQ'(1) << pick_idx;
          drive_d = bus.req_bit[pick_idx];
          owner_d = pick_idx;
        end
      end
      LINK_SETTLE: begin
        if (cnt_q == '0) state_d = LINK_SAMPLE;
        else             cnt_d   = cnt_q - CNTW'(1);
      end
      LINK_SAMPLE: begin
        // Completion edge: release the link and move priority past the owner.
        state_d     = LINK_IDLE;
        gnt_d       = '0;
        drive_d     = IDLE_VALUE;
        rsp_valid_d = 1'b1;
        rsp_bit_d   = bus.link_observe;
        rsp_id_d    = owner_q;
        ptr_d       = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + IDW'(1);
      end
      default: state_d = LINK_IDLE;
    endcase
  end

  assign bus.gnt        = gnt_q;
  assign bus.busy       = (state_q != LINK_IDLE);
  assign bus.link_drive = drive_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_bit    = rsp_bit_q;
  assign bus.rsp_id     = rsp_id_q;
  assign dbg_state_o    = state_q;
  assign dbg_ptr_o      = ptr_q;

endmodule

// File: tb/tb_onenet_link_arbiter.sv
// Bench for onenet_link_arbiter: loopback instance (S=2) and inverting instance (S=5).
module tb_onenet_link_arbiter;
  import onenet_link_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int W   = IDW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inv_a = 1'b0;
  logic inv_b = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] want_a, want_b;

  link_state_e    st_a, st_b;
  logic [IDW-1:0] ptr_a, ptr_b;

  onenet_link_arbiter_if #(.NUM_REQ(N)) bus_a();
  onenet_link_arbiter_if #(.NUM_REQ(N)) bus_b();

  assign bus_a.link_observe = bus_a.link_drive ^ inv_a;
  assign bus_b.link_observe = bus_b.link_drive ^ inv_b;

  onenet_link_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(2), .IDLE_VALUE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state_o(st_a), .dbg_ptr_o(ptr_a)
  );

  onenet_link_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(5), .IDLE_VALUE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state_o(st_b), .dbg_ptr_o(ptr_b)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboards: every response pops the oldest expected {id, bit}
  always @(negedge clk) begin
    if (bus_a.rsp_valid) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL sb_a_unexpected: got id=%0d bit=%0b, required no response", bus_a.rsp_id, bus_a.rsp_bit);
      end else begin
        want_a = exp_a.pop_front();
        if ({bus_a.rsp_id, bus_a.rsp_bit} !== want_a) begin
          errors++;
          $display("FAIL sb_a_rsp: got id=%0d bit=%0b, required id=%0d bit=%0b",
                   bus_a.rsp_id, bus_a.rsp_bit, want_a[W-1:1], want_a[0]);
        end
      end
    end
    if (bus_b.rsp_valid) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL sb_b_unexpected: got id=%0d bit=%0b, required no response", bus_b.rsp_id, bus_b.rsp_bit);
      end else begin
        want_b = exp_b.pop_front();
        if ({bus_b.rsp_id, bus_b.rsp_bit} !== want_b) begin
          errors++;
          $display("FAIL sb_b_rsp: got id=%0d bit=%0b, required id=%0d bit=%0b",
                   bus_b.rsp_id, bus_b.rsp_bit, want_b[W-1:1], want_b[0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.req = '0; bus_a.req_bit = '0;
    bus_b.req = '0; bus_b.req_bit = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_rsp_a(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus_a.rsp_valid) begin
        at_cyc = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL wait_rsp_a: got no rsp_valid within %0d cycles, required a pulse", budget);
  endtask

  task automatic wait_rsp_b(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus_b.rsp_valid) begin
        at_cyc = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL wait_rsp_b: got no rsp_valid within %0d cycles, required a pulse", budget);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({bus_a.gnt, bus_a.busy, bus_a.rsp_valid, bus_a.link_drive} !== 7'b0) begin
      errors++;
      $display("FAIL reset_a_ctrl: got gnt=%b busy=%b rsp_valid=%b drive=%b, required all 0",
               bus_a.gnt, bus_a.busy, bus_a.rsp_valid, bus_a.link_drive);
    end
    checks++;
    if ({bus_a.rsp_bit, bus_a.rsp_id, ptr_a} !== 5'b0 || st_a !== LINK_IDLE) begin
      errors++;
      $display("FAIL reset_a_regs: got rsp_bit=%b rsp_id=%0d ptr=%0d state=%0d, required 0/0/0/IDLE",
               bus_a.rsp_bit, bus_a.rsp_id, ptr_a, st_a);
    end
    checks++;
    if ({bus_b.gnt, bus_b.busy, bus_b.rsp_valid, bus_b.link_drive, ptr_b} !== 9'b0) begin
      errors++;
      $display("FAIL reset_b: got gnt=%b busy=%b rsp_valid=%b drive=%b ptr=%0d, required all 0",
               bus_b.gnt, bus_b.busy, bus_b.rsp_valid, bus_b.link_drive, ptr_b);
    end
  endtask

  task automatic test_single();
    int t0, at_cyc;
    logic [N-1:0] want_gnt;
    do_reset();
    inv_a = 1'b0;
    bus_a.req_bit = 4'b0100;
    bus_a.req     = 4'b0100;
    t0 = cyc;
    exp_a.push_back({2'd2, 1'b1});
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      want_gnt = (k == 0) ? 4'b0000 : 4'b0100;
      checks++;
      if (bus_a.gnt !== want_gnt || bus_a.link_drive !== want_gnt[2]) begin
        errors++;
        $display("FAIL single_gnt_t%0d: got gnt=%b drive=%b, required gnt=%b drive=%b",
                 k, bus_a.gnt, bus_a.link_drive, want_gnt, want_gnt[2]);
      end
      if (k == 1) bus_a.req = '0;
    end
    wait_rsp_a(3, at_cyc);
    checks++;
    if (at_cyc !== t0 + 4) begin
      errors++;
      $display("FAIL single_latency: got rsp at cycle %0d, required %0d", at_cyc, t0 + 4);
    end
    checks++;
    if ({bus_a.gnt, bus_a.busy, bus_a.link_drive} !== 6'b0) begin
      errors++;
      $display("FAIL single_release: got gnt=%b busy=%b drive=%b, required all 0",
               bus_a.gnt, bus_a.busy, bus_a.link_drive);
    end
    @(negedge clk);
    checks++;
    if (bus_a.rsp_valid !== 1'b0 || bus_a.rsp_bit !== 1'b1 || bus_a.rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL single_hold: got valid=%b bit=%b id=%0d, required 0/1/2",
               bus_a.rsp_valid, bus_a.rsp_bit, bus_a.rsp_id);
    end
  endtask

  task automatic test_fairness();
    int t0, at_cyc;
    logic [N-1:0] bits;
    do_reset();
    bits = 4'($urandom_range(0, 15));
    bus_a.req_bit = bits;
    bus_a.req     = 4'b1111;
    t0 = cyc;
    exp_a.push_back({2'd0, bits[0]});
    exp_a.push_back({2'd1, bits[1]});
    exp_a.push_back({2'd2, bits[2]});
    exp_a.push_back({2'd3, bits[3]});
    exp_a.push_back({2'd0, bits[0]});
    for (int k = 0; k < 5; k++) begin
      wait_rsp_a(8, at_cyc);
      if (k == 4) bus_a.req = '0;
      checks++;
      if (at_cyc !== t0 + 4*(k+1)) begin
        errors++;
        $display("FAIL fair_spacing_%0d: got rsp at cycle %0d, required %0d", k, at_cyc, t0 + 4*(k+1));
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_wrap();
    int at_cyc;
    logic [N-1:0] bits;
    do_reset();
    bits = 4'($urandom_range(0, 15));
    bus_a.req_bit = bits;
    bus_a.req     = 4'b1000;
    exp_a.push_back({2'd3, bits[3]});
    wait_rsp_a(8, at_cyc);
    checks++;
    if (ptr_a !== 2'd0) begin
      errors++;
      $display("FAIL wrap_ptr: got ptr=%0d, required 0", ptr_a);
    end
    bus_a.req = 4'b1010;
    exp_a.push_back({2'd1, bits[1]});
    @(negedge clk);
    checks++;
    if (bus_a.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_gnt1: got gnt=%b, required 0010", bus_a.gnt);
    end
    wait_rsp_a(8, at_cyc);
    bus_a.req = 4'b1000;
    exp_a.push_back({2'd3, bits[3]});
    @(negedge clk);
    checks++;
    if (bus_a.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_gnt3: got gnt=%b, required 1000", bus_a.gnt);
    end
    wait_rsp_a(8, at_cyc);
    bus_a.req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_inverting();
    int t0, at_cyc;
    do_reset();
    inv_b = 1'b1;
    bus_b.req_bit = 4'b0000;
    bus_b.req     = 4'b0001;
    t0 = cyc;
    exp_b.push_back({2'd0, 1'b1});
    wait_rsp_b(12, at_cyc);
    checks++;
    if (at_cyc !== t0 + 7) begin
      errors++;
      $display("FAIL inv_latency0: got rsp at cycle %0d, required %0d", at_cyc, t0 + 7);
    end
    bus_b.req_bit = 4'b0100;
    bus_b.req     = 4'b0100;
    t0 = cyc;
    exp_b.push_back({2'd2, 1'b0});
    wait_rsp_b(12, at_cyc);
    bus_b.req = '0;
    checks++;
    if (at_cyc !== t0 + 7) begin
      errors++;
      $display("FAIL inv_latency2: got rsp at cycle %0d, required %0d", at_cyc, t0 + 7);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t1, at_cyc;
    logic [N-1:0] bits;
    do_reset();
    bits = 4'($urandom_range(0, 15));
    bus_a.req_bit = bits;
    bus_a.req     = 4'b0010;
    exp_a.push_back({2'd1, bits[1]});
    wait_rsp_a(8, at_cyc);
    bus_a.req = '0;
    tick();
    bus_a.req_bit = 4'b1000;
    bus_a.req     = 4'b1000;
    tick();
    tick();
    rst = 1'b1;
    bus_a.req = '0;
    @(negedge clk);
    checks++;
    if (bus_a.busy !== 1'b1 || bus_a.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL mid_settle: got busy=%b gnt=%b, required 1/1000", bus_a.busy, bus_a.gnt);
    end
    @(negedge clk);
    checks++;
    if ({bus_a.gnt, bus_a.busy, bus_a.link_drive, bus_a.rsp_valid, ptr_a} !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset: got gnt=%b busy=%b drive=%b rsp_valid=%b ptr=%0d, required all 0",
               bus_a.gnt, bus_a.busy, bus_a.link_drive, bus_a.rsp_valid, ptr_a);
    end
    rst = 1'b0;
    bits = 4'($urandom_range(0, 15));
    bus_a.req_bit = bits;
    bus_a.req     = 4'b0110;
    t1 = cyc;
    exp_a.push_back({2'd1, bits[1]});
    wait_rsp_a(8, at_cyc);
    bus_a.req = '0;
    checks++;
    if (at_cyc !== t1 + 4) begin
      errors++;
      $display("FAIL mid_next_latency: got rsp at cycle %0d, required %0d", at_cyc, t1 + 4);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus_a.req = '0; bus_a.req_bit = '0;
    bus_b.req = '0; bus_b.req_bit = '0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_inverting();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_a.size() != 0) begin
      errors++;
      $display("FAIL sb_a_drain: got %0d responses outstanding, required 0", exp_a.size());
    end
    checks++;
    if (exp_b.size() != 0) begin
      errors++;
      $display("FAIL sb_b_drain: got %0d responses outstanding, required 0", exp_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
